// File: rtl/fei4_cmd_pkg.sv
// Shared constants and state encoding for the FE-I4 command-line arbiter.
package fei4_cmd_pkg;

    localparam logic [4:0] CMD_LV1     = 5'b11101;
    localparam int         CMD_LV1_LEN = 5;

    typedef enum logic [1:0] {
        IDLE,
        SEND_LV1,
        SEND_SEQ,
        GAP
    } arb_state_t;

endpackage

// File: rtl/cmd_shift_out.sv
// MSB-first serialiser: loads a left-aligned word and drives len_i bits, one per clock,
// on a registered output; last_o marks the cycle the final bit is on the line.
module cmd_shift_out #(
    parameter int W  = 64,
    parameter int LW = 7
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          load_i,
    input  logic [LW-1:0] len_i,
    input  logic [W-1:0]  data_i,
    output logic          dout_o,
    output logic          last_o
);

    logic [W-1:0]  sreg_q;
    logic [LW-1:0] cnt_q;
    logic          act_q;
    logic          dout_q;

    // The first bit goes straight to the output register on load, so cnt_q
    // counts the bits still to follow the one currently driven.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sreg_q <= '0;
            cnt_q  <= '0;
            act_q  <= 1'b0;
            dout_q <= 1'b0;
        end else if (load_i) begin
            dout_q <= data_i[W-1];
            sreg_q <= {data_i[W-2:0], 1'b0};
            cnt_q  <= len_i - LW'(1);
            act_q  <= 1'b1;
        end else if (act_q) begin
            if (cnt_q == '0) begin
                act_q  <= 1'b0;
                dout_q <= 1'b0;
            end else begin
                dout_q <= sreg_q[W-1];
                sreg_q <= {sreg_q[W-2:0], 1'b0};
                cnt_q  <= cnt_q - LW'(1);
            end
        end
    end

    assign dout_o = dout_q;
    assign last_o = act_q && (cnt_q == '0);

endmodule

// File: rtl/fei4_cmd_arbiter.sv
// Arbitrates the single FE-I4 command line between queued LV1 triggers and the
// software sequencer; LV1 wins every arbitration point and nothing is preempted.
module fei4_cmd_arbiter #(
    parameter int SEQ_MAX_BITS = 64,
    parameter int LV1_QDEPTH   = 4,
    parameter int IDLE_GAP     = 1
) (
    input  logic                                CMD_CLK,
    input  logic                                RST_B,
    input  logic                                TRIG_EN,
    input  logic                                TRIG_REQ,
    input  logic                                SEQ_REQ,
    input  logic [SEQ_MAX_BITS-1:0]             SEQ_DATA,
    input  logic [$clog2(SEQ_MAX_BITS+1)-1:0]   SEQ_LEN,
    output logic                                SEQ_ACK,
    output logic                                SEQ_DONE,
    input  logic                                CLR_CNT,
    output logic                                CMD_DATA,
    output logic                                BUSY,
    output logic [$clog2(LV1_QDEPTH+1)-1:0]     LV1_PENDING,
    output logic [15:0]                         LV1_CNT,
    output logic [15:0]                         DROP_CNT
);

    import fei4_cmd_pkg::*;

    localparam int LW = $clog2(SEQ_MAX_BITS + 1);
    localparam int QW = $clog2(LV1_QDEPTH + 1);
    localparam int GW = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

    arb_state_t        state_q, state_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [QW-1:0]     pend_q, pend_d;
    logic              trig_q;
    logic [15:0]       lv1_cnt_q, lv1_cnt_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;

    logic              deq, load, ack, done_zero;
    logic [LW-1:0]     ld_len, seq_len_c;
    logic [SEQ_MAX_BITS-1:0] ld_data;
    logic              sh_dout, sh_last;
    logic              q_full, drop;

    assign seq_len_c = (SEQ_LEN > LW'(SEQ_MAX_BITS)) ? LW'(SEQ_MAX_BITS) : SEQ_LEN;

    always_ff @(posedge CMD_CLK or negedge RST_B) begin
        if (!RST_B) begin
            state_q    <= IDLE;
            gap_q      <= '0;
            pend_q     <= '0;
            trig_q     <= 1'b0;
            lv1_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            pend_q     <= pend_d;
            trig_q     <= TRIG_REQ & TRIG_EN;
            lv1_cnt_q  <= lv1_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        deq       = 1'b0;
        load      = 1'b0;
        ack       = 1'b0;
        done_zero = 1'b0;
        ld_len    = '0;
        ld_data   = '0;
        case (state_q)
            IDLE: begin
                if (pend_q != '0) begin
                    deq     = 1'b1;
                    load    = 1'b1;
                    ld_len  = LW'(CMD_LV1_LEN);
                    ld_data = {CMD_LV1, {(SEQ_MAX_BITS-CMD_LV1_LEN){1'b0}}};
                    state_d = SEND_LV1;
                end else if (SEQ_REQ) begin
                    ack = 1'b1;
                    if (seq_len_c != '0) begin
                        load    = 1'b1;
                        ld_len  = seq_len_c;
                        ld_data = SEQ_DATA;
                        state_d = SEND_SEQ;
                    end else begin
                        done_zero = 1'b1;
                    end
                end
            end
            SEND_LV1, SEND_SEQ: begin
                // The IDLE cycle itself is the final gap bit, so GAP holds IDLE_GAP-1.
                if (sh_last) begin
                    if (IDLE_GAP > 1) begin
                        state_d = GAP;
                        gap_d   = GW'(IDLE_GAP - 2);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            GAP: begin
                if (gap_q == '0) state_d = IDLE;
                else             gap_d   = gap_q - GW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    assign q_full = (pend_q == QW'(LV1_QDEPTH));
    assign drop   = trig_q && !deq && q_full;

    always_comb begin
        pend_d = pend_q;
        if (trig_q && !deq && !q_full) pend_d = pend_q + QW'(1);
        else if (!trig_q && deq)       pend_d = pend_q - QW'(1);
    end

    always_comb begin
        lv1_cnt_d  = lv1_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (CLR_CNT) begin
            lv1_cnt_d  = '0;
            drop_cnt_d = '0;
        end else begin
            if (state_q == SEND_LV1 && sh_last)   lv1_cnt_d  = lv1_cnt_q + 16'd1;
            if (drop && drop_cnt_q != 16'hFFFF)   drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    cmd_shift_out #(
        .W  (SEQ_MAX_BITS),
        .LW (LW)
    ) u_shift (
        .clk_i  (CMD_CLK),
        .rst_ni (RST_B),
        .load_i (load),
        .len_i  (ld_len),
        .data_i (ld_data),
        .dout_o (sh_dout),
        .last_o (sh_last)
    );

    // ACK/DONE decode live inputs in IDLE; hold them low while reset is asserted.
    assign SEQ_ACK     = ack & RST_B;
    assign SEQ_DONE    = (done_zero | (state_q == SEND_SEQ && sh_last)) & RST_B;
    assign CMD_DATA    = sh_dout;
    assign BUSY        = (state_q != IDLE) || (pend_q != '0);
    assign LV1_PENDING = pend_q;
    assign LV1_CNT     = lv1_cnt_q;
    assign DROP_CNT    = drop_cnt_q;

endmodule
